// File: rtl/mem_byte_seq_pkg.sv
// Shared definitions for the byte-serial memory sequencer: width codes,
// FSM encodings, boolean and zero constants, and the byte-count helper.
package mem_byte_seq_pkg;

  localparam logic        True_v   = 1'b1;
  localparam logic        False_v  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // funct3 width/sign codes
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Index of the final byte of an access (byte count minus one).
  // Unknown codes fall back to a full word.
  function automatic logic [1:0] last_index(input logic [2:0] funct3);
    logic [1:0] idx;
    case (funct3)
      F3_B, F3_BU: idx = 2'd0;
      F3_H, F3_HU: idx = 2'd1;
      default:     idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_byte_seq_if.sv
// Byte-wide memory port between the sequencer (master) and the
// arbiter/memory side (slave). Read data returns one cycle after the address.
interface mem_byte_seq_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_data_o;
  logic [7:0]        mem_data_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_data_i
  );
endinterface

// File: rtl/mem_load_ext.sv
// Load-result extension: turns the little-endian byte assembly into the
// architectural register value according to the access width/sign code.
module mem_load_ext
  import mem_byte_seq_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  // Select sign/zero extension from the width code; words pass through raw
  always_comb begin
    ext_o = raw_i;
    case (funct3_i)
      F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_BU:   ext_o = {24'h00_0000, raw_i[7:0]};
      F3_HU:   ext_o = {16'h0000, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_byte_seq.sv
// Byte-serial load/store sequencer. An accepted access is split into 1, 2
// or 4 single-byte requests at consecutive (wrapping) addresses. Load bytes
// are assembled little-endian and extended when the access completes.
// A low rdy freezes the block; a read whose data would have been consumed
// during a frozen cycle is dropped and that byte is issued again.
module mem_byte_seq
  import mem_byte_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  mem_byte_seq_if.master    mem,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o
);

  state_e            state_r;
  state_e            state_s;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [1:0]        cnt_r;
  logic [1:0]        last_r;
  logic              pend_r;
  logic [1:0]        pend_idx_r;
  logic [31:0]       result_r;
  logic [31:0]       ext_s;

  logic              accept_s;
  logic              issue_s;
  logic              capture_s;
  logic              drop_s;

  // Per-cycle control qualifiers; nothing advances while rdy is low
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && req_i && rdy;
    issue_s   = (state_r == ST_XFER) && rdy;
    capture_s = pend_r && rdy;
    drop_s    = pend_r && !rdy;
  end

  // Next-state logic; a dropped final read sends LAST back to XFER to reissue it
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_XFER;
        else          state_s = ST_IDLE;
      end
      ST_XFER: begin
        if (issue_s && (cnt_r == last_r)) state_s = we_r ? ST_DONE : ST_LAST;
        else                              state_s = ST_XFER;
      end
      ST_LAST: begin
        if (drop_s)   state_s = ST_XFER;
        else if (rdy) state_s = ST_DONE;
        else          state_s = ST_LAST;
      end
      ST_DONE: begin
        if (rdy) state_s = ST_IDLE;
        else     state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Operation latch, byte counter, pending-read tracking and load assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r       <= False_v;
      funct3_r   <= 3'd0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= ZeroWord;
      cnt_r      <= 2'd0;
      last_r     <= 2'd0;
      pend_r     <= False_v;
      pend_idx_r <= 2'd0;
      result_r   <= ZeroWord;
    end else if (accept_s) begin
      we_r       <= we_i;
      funct3_r   <= funct3_i;
      addr_r     <= addr_i;
      wdata_r    <= wdata_i;
      cnt_r      <= 2'd0;
      last_r     <= last_index(funct3_i);
      pend_r     <= False_v;
      pend_idx_r <= 2'd0;
      result_r   <= ZeroWord;
    end else if (drop_s) begin
      // read data arrived while frozen: forget it and rewind to that byte
      pend_r <= False_v;
      cnt_r  <= pend_idx_r;
    end else if (rdy) begin
      if (capture_s) begin
        result_r[{pend_idx_r, 3'b000} +: 8] <= mem.mem_data_i;
      end
      if (issue_s) begin
        cnt_r      <= cnt_r + 2'd1;
        pend_r     <= ~we_r;
        pend_idx_r <= cnt_r;
      end else begin
        pend_r <= False_v;
      end
    end
  end

  mem_load_ext u_load_ext (
    .funct3_i (funct3_r),
    .raw_i    (result_r),
    .ext_o    (ext_s)
  );

  // Byte port drive: active only on issue cycles, otherwise held at zero
  always_comb begin
    mem.mem_req_o  = False_v;
    mem.mem_we_o   = False_v;
    mem.mem_addr_o = {ADDR_W{1'b0}};
    mem.mem_data_o = 8'h00;
    if (issue_s) begin
      mem.mem_req_o  = True_v;
      mem.mem_we_o   = we_r;
      mem.mem_addr_o = addr_r + ADDR_W'(cnt_r);
      mem.mem_data_o = we_r ? wdata_r[{cnt_r, 3'b000} +: 8] : 8'h00;
    end else begin
      mem.mem_req_o  = False_v;
    end
  end

  // Status and result outputs; load data is exposed only during DONE
  always_comb begin
    busy_o  = (state_r != ST_IDLE);
    done_o  = (state_r == ST_DONE);
    rdata_o = ZeroWord;
    if (done_o && !we_r) rdata_o = ext_s;
    else                 rdata_o = ZeroWord;
  end

endmodule

// File: tb/tb_mem_byte_seq.sv
// Directed bench for mem_byte_seq with a one-cycle-latency byte memory model.
module tb_mem_byte_seq;
  import mem_byte_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          base;
  logic [31:0] last_wa = 32'h0;
  logic [7:0]  last_wd = 8'h00;

  mem_byte_seq_if #(.ADDR_W(32)) bus ();

  mem_byte_seq #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .req_i    (req_i),
    .we_i     (we_i),
    .funct3_i (funct3_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .mem      (bus),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .rdata_o  (rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0000_0007: return 8'h80;
      32'h0000_0200: return 8'h34;
      32'h0000_0201: return 8'h92;
      default:       return 8'h00;
    endcase
  endfunction

  // Memory model: read data one cycle after the request, writes logged
  always @(posedge clk) begin
    if (bus.mem_req_o && !bus.mem_we_o) bus.mem_data_i <= ram_byte(bus.mem_addr_o);
    else                                bus.mem_data_i <= 8'h00;
    if (bus.mem_req_o && bus.mem_we_o) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= bus.mem_addr_o;
      last_wd <= bus.mem_data_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic we,
                         input logic [31:0] addr, input logic [7:0] data);
    chk({tag, "_req"},  {31'd0, bus.mem_req_o}, {31'd0, req});
    chk({tag, "_we"},   {31'd0, bus.mem_we_o},  {31'd0, we});
    chk({tag, "_addr"}, bus.mem_addr_o,         addr);
    chk({tag, "_data"}, {24'd0, bus.mem_data_o}, {24'd0, data});
  endtask

  task automatic chk_quiet(input string tag);
    chk_bus(tag, 1'b0, 1'b0, 32'h0, 8'h00);
    chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    chk({tag, "_done"},  {31'd0, done_o}, 32'd0);
    chk({tag, "_rdata"}, rdata_o,         32'd0);
  endtask

  initial begin
    // reset with inputs asserted: everything must stay zero
    rst_n = 1'b0; rdy = 1'b1; req_i = 1'b1; we_i = 1'b1;
    funct3_i = F3_W; addr_i = 32'h100; wdata_i = 32'hFFFF_FFFF;
    #12;
    chk_quiet("reset");
    req_i = 1'b0;
    #6;
    rst_n = 1'b1;
    tick();

    // LW at 0x100 -> 0x44332211, done at A+6
    we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h100; req_i = 1'b1;
    #2; chk("lw_a_busy", {31'd0, busy_o}, 32'd0);
    tick(); req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2; chk_bus($sformatf("lw_b%0d", k), 1'b1, 1'b0, 32'h100 + k, 8'h00);
      chk($sformatf("lw_b%0d_done", k), {31'd0, done_o}, 32'd0);
      tick();
    end
    #2; chk("lw_last_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("lw_last_busy", {31'd0, busy_o}, 32'd1);
    chk("lw_last_done", {31'd0, done_o}, 32'd0);
    tick();
    #2; chk("lw_done", {31'd0, done_o}, 32'd1);
    chk("lw_rdata", rdata_o, 32'h4433_2211);
    tick();
    #2; chk_quiet("lw_after");
    tick();

    // LBU at 0x7 -> 0x80 zero-extended, done at A+3; a req pulse mid-access is dropped
    we_i = 1'b0; funct3_i = F3_BU; addr_i = 32'h7; req_i = 1'b1;
    tick(); req_i = 1'b0;
    #2; chk_bus("lbu_b0", 1'b1, 1'b0, 32'h7, 8'h00);
    tick();
    req_i = 1'b1;
    #2; chk("lbu_last_done", {31'd0, done_o}, 32'd0);
    tick(); req_i = 1'b0;
    #2; chk("lbu_done", {31'd0, done_o}, 32'd1);
    chk("lbu_rdata", rdata_o, 32'h0000_0080);
    tick();
    #2; chk_quiet("lbu_idle0");
    tick();
    #2; chk_quiet("lbu_idle1");
    tick();

    // LH at 0x200 -> 0x9234 sign-extended, done at A+4
    we_i = 1'b0; funct3_i = F3_H; addr_i = 32'h200; req_i = 1'b1;
    tick(); req_i = 1'b0;
    #2; chk_bus("lh_b0", 1'b1, 1'b0, 32'h200, 8'h00);
    tick();
    #2; chk_bus("lh_b1", 1'b1, 1'b0, 32'h201, 8'h00);
    tick();
    tick();
    #2; chk("lh_done", {31'd0, done_o}, 32'd1);
    chk("lh_rdata", rdata_o, 32'hFFFF_9234);
    tick();
    tick();

    // SH 0xBEEF at 0xFFFFFFFF: wraps to 0x0, done at A+3
    base = wr_cnt;
    we_i = 1'b1; funct3_i = F3_H; addr_i = 32'hFFFF_FFFF; wdata_i = 32'h1234_BEEF; req_i = 1'b1;
    tick(); req_i = 1'b0;
    #2; chk_bus("sh_b0", 1'b1, 1'b1, 32'hFFFF_FFFF, 8'hEF);
    tick();
    #2; chk_bus("sh_b1", 1'b1, 1'b1, 32'h0000_0000, 8'hBE);
    tick();
    #2; chk("sh_done", {31'd0, done_o}, 32'd1);
    chk("sh_rdata", rdata_o, 32'd0);
    chk("sh_nwr", wr_cnt - base, 32'd2);
    chk("sh_last_wa", last_wa, 32'h0000_0000);
    chk("sh_last_wd", {24'd0, last_wd}, 32'h0000_00BE);
    tick();
    tick();

    // LW with rdy low for two cycles right after byte 1 is issued:
    // byte 1 is dropped and reissued, so done moves from A+6 to A+9
    we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h100; req_i = 1'b1;
    tick(); req_i = 1'b0;
    #2; chk_bus("st_b0", 1'b1, 1'b0, 32'h100, 8'h00);
    tick();
    #2; chk_bus("st_b1", 1'b1, 1'b0, 32'h101, 8'h00);
    tick();
    rdy = 1'b0;
    #2; chk("st_frz0_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("st_frz0_busy", {31'd0, busy_o}, 32'd1);
    tick();
    #2; chk("st_frz1_req", {31'd0, bus.mem_req_o}, 32'd0);
    tick();
    rdy = 1'b1;
    #2; chk_bus("st_re_b1", 1'b1, 1'b0, 32'h101, 8'h00);
    tick();
    #2; chk_bus("st_b2", 1'b1, 1'b0, 32'h102, 8'h00);
    tick();
    #2; chk_bus("st_b3", 1'b1, 1'b0, 32'h103, 8'h00);
    tick();
    #2; chk("st_last_done", {31'd0, done_o}, 32'd0);
    tick();
    #2; chk("st_done", {31'd0, done_o}, 32'd1);
    chk("st_rdata", rdata_o, 32'h4433_2211);
    tick();
    tick();

    // SW interrupted by reset during byte 2: outputs drop at once, no resume
    base = wr_cnt;
    we_i = 1'b1; funct3_i = F3_W; addr_i = 32'h300; wdata_i = 32'hA1B2_C3D4; req_i = 1'b1;
    tick(); req_i = 1'b0;
    #2; chk_bus("sw_b0", 1'b1, 1'b1, 32'h300, 8'hD4);
    tick();
    #2; chk_bus("sw_b1", 1'b1, 1'b1, 32'h301, 8'hC3);
    tick();
    #2; chk_bus("sw_b2", 1'b1, 1'b1, 32'h302, 8'hB2);
    rst_n = 1'b0;
    #1; chk_quiet("sw_rst_now");
    tick();
    #2; chk_quiet("sw_rst_hold");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #2; chk_quiet($sformatf("sw_post%0d", i));
      tick();
    end
    chk("sw_nwr", wr_cnt - base, 32'd2);

    // LB at 0x7 with req held through DONE: one idle cycle, then restart
    we_i = 1'b0; funct3_i = F3_B; addr_i = 32'h7; req_i = 1'b1;
    #2; chk("hold_a_busy", {31'd0, busy_o}, 32'd0);
    tick();
    #2; chk_bus("hold_b0", 1'b1, 1'b0, 32'h7, 8'h00);
    tick();
    #2; chk("hold_last_busy", {31'd0, busy_o}, 32'd1);
    tick();
    #2; chk("hold_done", {31'd0, done_o}, 32'd1);
    chk("hold_rdata", rdata_o, 32'hFFFF_FF80);
    chk("hold_done_busy", {31'd0, busy_o}, 32'd1);
    tick();
    #2; chk("hold_gap_busy", {31'd0, busy_o}, 32'd0);
    chk("hold_gap_req", {31'd0, bus.mem_req_o}, 32'd0);
    tick();
    #2; chk("hold_2nd_busy", {31'd0, busy_o}, 32'd1);
    chk_bus("hold_2nd_b0", 1'b1, 1'b0, 32'h7, 8'h00);
    req_i = 1'b0;
    tick();
    tick();
    #2; chk("hold_2nd_done", {31'd0, done_o}, 32'd1);
    chk("hold_2nd_rdata", rdata_o, 32'hFFFF_FF80);
    tick();
    #2; chk_quiet("hold_end0");
    tick();
    #2; chk_quiet("hold_end1");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
